// File: rtl/outport_drain_buffer_if.sv
// Bundle of the Outport capture and device-drain signals for outport_drain_buffer.
// With OUTPORT_DRAIN_PARITY_EN defined, a dev_parity line joins the bundle.
interface outport_drain_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
);
  // CPU side
  logic [DATA_W-1:0] out_data;
  logic              out_strobe;

  // Device side
  // A word moves when dev_valid and dev_ready are both high on a rising clk
  // edge. dev_valid, once high, stays high and dev_data stays stable until
  // that edge. dev_ready may toggle freely and is ignored while dev_valid is low.
  logic [DATA_W-1:0] dev_data;
  logic              dev_valid;
  logic              dev_ready;
`ifdef OUTPORT_DRAIN_PARITY_EN
  logic              dev_parity;
`endif

  // Status and control
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              ovf_clr;

  // Debug view of the control FSM (1 = HOLD, 0 = EMPTY)
  logic              fsm_state;

  modport slave (
    input  out_data, out_strobe, dev_ready, ovf_clr,
    output dev_data, dev_valid,
`ifdef OUTPORT_DRAIN_PARITY_EN
    output dev_parity,
`endif
    output full, empty, count, overflow, fsm_state
  );

  modport master (
    output out_data, out_strobe, dev_ready, ovf_clr,
    input  dev_data, dev_valid,
`ifdef OUTPORT_DRAIN_PARITY_EN
    input  dev_parity,
`endif
    input  full, empty, count, overflow, fsm_state
  );
endinterface

// File: rtl/outport_drain_buffer.sv
// Captures each rising edge of the Outport strobe into a small FIFO and drains it to a device.
// Optional macro OUTPORT_DRAIN_PARITY_EN adds a registered per-word even-parity output.
module outport_drain_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  outport_drain_buffer_if.slave bus
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_COUNT  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  state_t            state_q, state_d;
  logic              strobe_q, strobe_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] dev_data_q, dev_data_d;
  logic              overflow_q, overflow_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              push;
  logic              pop;
  logic              is_full;
  logic              accept;
  logic [ADDR_W-1:0] rd_next;

`ifdef OUTPORT_DRAIN_PARITY_EN
  logic              par_mem_q [DEPTH];
  logic              dev_parity_q, dev_parity_d;
  logic              in_parity;

  assign in_parity = ^bus.out_data;
`endif

  // One push per strobe rising edge; strobe_q resets low so a strobe already
  // high when clr drops still counts as a new write.
  always_comb begin
    push    = bus.out_strobe & ~strobe_q;
    pop     = (state_q == ST_HOLD) & bus.dev_ready;
    is_full = (count_q == FULL_COUNT);
    accept  = push & (~is_full | pop);
    rd_next = rd_ptr_q + PTR_ONE;
  end

  // Pointers, count, strobe history and the sticky overflow flag
  always_comb begin
    strobe_d   = bus.out_strobe;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)    rd_ptr_d = rd_next;

    case ({accept, pop})
      2'b10:   count_d = count_q + ONE_COUNT;
      2'b01:   count_d = count_q - ONE_COUNT;
      default: count_d = count_q;
    endcase

    if (bus.ovf_clr) overflow_d = 1'b0;
    // A drop on the same edge as ovf_clr must win.
    if (push && is_full && !pop) overflow_d = 1'b1;
  end

  // Control FSM and the registered head word. The head is loaded from out_data
  // when the FIFO fills from empty, or refilled from storage on a pop.
  always_comb begin
    state_d    = state_q;
    dev_data_d = dev_data_q;
`ifdef OUTPORT_DRAIN_PARITY_EN
    dev_parity_d = dev_parity_q;
`endif

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d    = ST_HOLD;
          dev_data_d = bus.out_data;
`ifdef OUTPORT_DRAIN_PARITY_EN
          dev_parity_d = in_parity;
`endif
        end
      end
      ST_HOLD: begin
        if (pop) begin
          if (count_q > ONE_COUNT) begin
            dev_data_d = mem_q[rd_next];
`ifdef OUTPORT_DRAIN_PARITY_EN
            dev_parity_d = par_mem_q[rd_next];
`endif
          end else if (accept) begin
            dev_data_d = bus.out_data;
`ifdef OUTPORT_DRAIN_PARITY_EN
            dev_parity_d = in_parity;
`endif
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_EMPTY;
      strobe_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dev_data_q <= '0;
      overflow_q <= 1'b0;
`ifdef OUTPORT_DRAIN_PARITY_EN
      dev_parity_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      strobe_q   <= strobe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dev_data_q <= dev_data_d;
      overflow_q <= overflow_d;
`ifdef OUTPORT_DRAIN_PARITY_EN
      dev_parity_q <= dev_parity_d;
`endif
    end
  end

  // Storage needs no reset: the pointers alone decide which slots are live.
  // Writing the slot of a word being popped while full is safe because the
  // head is already held in dev_data_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= bus.out_data;
`ifdef OUTPORT_DRAIN_PARITY_EN
      par_mem_q[wr_ptr_q] <= in_parity;
`endif
    end
  end

  assign bus.dev_data  = dev_data_q;
  assign bus.dev_valid = (state_q == ST_HOLD);
  assign bus.full      = is_full;
  assign bus.empty     = (count_q == '0);
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.fsm_state = state_q;
`ifdef OUTPORT_DRAIN_PARITY_EN
  assign bus.dev_parity = dev_parity_q;
`endif

endmodule

// File: tb/tb_outport_drain_buffer.sv
// Directed bench for outport_drain_buffer: strobe edge detect, FIFO order, full/overflow, async clear.
// Build with OUTPORT_DRAIN_PARITY_EN defined to also cover dev_parity.
module tb_outport_drain_buffer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 2;

  logic clk;
  logic clr;
  int   checks;
  int   errors;

  outport_drain_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  outport_drain_buffer #(.DATA_W(DATA_W), .DEPTH(4), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, run did not finish");
    $fatal(1, "watchdog");
  end

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] data);
    bus.out_data   = data;
    bus.out_strobe = 1'b1;
    tick();
    bus.out_strobe = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.out_data = '0; bus.out_strobe = 1'b0; bus.dev_ready = 1'b0; bus.ovf_clr = 1'b0;
    #2;
    checks++; if (bus.dev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.dev_valid); end
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%0b full=%0b want 1/0", bus.empty, bus.full); end
    checks++; if (bus.count !== 3'd0 || bus.overflow !== 1'b0 || bus.dev_data !== 32'h0) begin errors++; $display("FAIL reset_state got count=%0d ovf=%0b data=%h want 0/0/0", bus.count, bus.overflow, bus.dev_data); end
    tick();
    #2 clr = 1'b0;
    tick();
    // dev_ready while empty must be ignored
    bus.dev_ready = 1'b1;
    tick();
    checks++; if (bus.count !== 3'd0 || bus.dev_valid !== 1'b0) begin errors++; $display("FAIL empty_ready got count=%0d valid=%0b want 0/0", bus.count, bus.dev_valid); end
    bus.dev_ready = 1'b0;
  endtask

  task automatic test_single_push();
    bus.out_data = 32'h0000_0032; bus.out_strobe = 1'b1;
    tick();
    bus.out_strobe = 1'b0;
    checks++; if (bus.dev_valid !== 1'b1 || bus.dev_data !== 32'h32 || bus.count !== 3'd1) begin errors++; $display("FAIL single_push got valid=%0b data=%h count=%0d want 1/32/1", bus.dev_valid, bus.dev_data, bus.count); end
    bus.out_data = 32'hdead_beef;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.dev_valid !== 1'b1 || bus.dev_data !== 32'h32) begin errors++; $display("FAIL hold_%0d got valid=%0b data=%h want 1/32", i, bus.dev_valid, bus.dev_data); end
    end
    bus.dev_ready = 1'b1;
    tick();
    bus.dev_ready = 1'b0;
    checks++; if (bus.empty !== 1'b1 || bus.dev_valid !== 1'b0) begin errors++; $display("FAIL single_drain got empty=%0b valid=%0b want 1/0", bus.empty, bus.dev_valid); end
  endtask

  task automatic test_held_strobe();
    bus.out_data = 32'h12; bus.out_strobe = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.out_strobe = 1'b0;
    tick();
    checks++; if (bus.count !== 3'd1 || bus.dev_data !== 32'h12) begin errors++; $display("FAIL held_strobe got count=%0d data=%h want 1/12", bus.count, bus.dev_data); end
    bus.dev_ready = 1'b1;
    tick();
    bus.dev_ready = 1'b0;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL held_drain got count=%0d want 0", bus.count); end
  endtask

  task automatic test_full_overflow();
    logic [DATA_W-1:0] exp_q[$];
    exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    foreach (exp_q[i]) push_word(exp_q[i]);
    checks++; if (bus.full !== 1'b1 || bus.count !== 3'd4) begin errors++; $display("FAIL fill got full=%0b count=%0d want 1/4", bus.full, bus.count); end
    push_word(32'h55);
    checks++; if (bus.overflow !== 1'b1 || bus.count !== 3'd4) begin errors++; $display("FAIL drop got ovf=%0b count=%0d want 1/4", bus.overflow, bus.count); end
    bus.dev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.dev_valid !== 1'b1 || bus.dev_data !== exp_q[i]) begin errors++; $display("FAIL drain_%0d got valid=%0b data=%h want 1/%h", i, bus.dev_valid, bus.dev_data, exp_q[i]); end
      tick();
    end
    bus.dev_ready = 1'b0;
    checks++; if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin errors++; $display("FAIL after_drain got empty=%0b ovf=%0b want 1/1", bus.empty, bus.overflow); end
  endtask

  task automatic test_push_pop_full();
    logic [DATA_W-1:0] exp_q[$];
    push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
    bus.out_data = 32'h66; bus.out_strobe = 1'b1; bus.dev_ready = 1'b1;
    tick();
    bus.out_strobe = 1'b0;
    checks++; if (bus.count !== 3'd4 || bus.full !== 1'b1 || bus.dev_data !== 32'h22) begin errors++; $display("FAIL push_pop_full got count=%0d full=%0b data=%h want 4/1/22", bus.count, bus.full, bus.dev_data); end
    exp_q = '{32'h22, 32'h33, 32'h44, 32'h66};
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.dev_valid !== 1'b1 || bus.dev_data !== exp_q[i]) begin errors++; $display("FAIL ppf_drain_%0d got valid=%0b data=%h want 1/%h", i, bus.dev_valid, bus.dev_data, exp_q[i]); end
      tick();
    end
    bus.dev_ready = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ppf_empty got %0b want 1", bus.empty); end
  endtask

  task automatic test_ovf_clr();
    push_word(32'ha1); push_word(32'ha2); push_word(32'ha3); push_word(32'ha4);
    bus.out_data = 32'h55; bus.out_strobe = 1'b1; bus.ovf_clr = 1'b1;
    tick();
    bus.out_strobe = 1'b0;
    checks++; if (bus.overflow !== 1'b1 || bus.count !== 3'd4) begin errors++; $display("FAIL set_wins got ovf=%0b count=%0d want 1/4", bus.overflow, bus.count); end
    tick();
    bus.ovf_clr = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %0b want 0", bus.overflow); end
  endtask

  task automatic test_async_clear();
    // Still full from the previous task: drop one to set overflow again.
    push_word(32'h99);
    bus.dev_ready = 1'b1;
    tick();
    bus.dev_ready = 1'b0;
    checks++; if (bus.count !== 3'd3 || bus.overflow !== 1'b1 || bus.dev_data !== 32'ha2) begin errors++; $display("FAIL pre_clear got count=%0d ovf=%0b data=%h want 3/1/a2", bus.count, bus.overflow, bus.dev_data); end
    #2 clr = 1'b1;
    #1;
    checks++; if (bus.dev_valid !== 1'b0 || bus.count !== 3'd0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL async_clear got valid=%0b count=%0d ovf=%0b want 0/0/0", bus.dev_valid, bus.count, bus.overflow); end
    // Strobe raised during reset counts as a fresh edge once clr drops.
    bus.out_data = 32'h77; bus.out_strobe = 1'b1;
    tick();
    #2 clr = 1'b0;
    tick();
    bus.out_strobe = 1'b0;
    checks++; if (bus.count !== 3'd1 || bus.dev_data !== 32'h77 || bus.dev_valid !== 1'b1) begin errors++; $display("FAIL strobe_after_clr got count=%0d data=%h valid=%0b want 1/77/1", bus.count, bus.dev_data, bus.dev_valid); end
    bus.dev_ready = 1'b1;
    tick();
    bus.dev_ready = 1'b0;
  endtask

`ifdef OUTPORT_DRAIN_PARITY_EN
  task automatic test_parity();
    push_word(32'h0000_0007);
    checks++; if (bus.dev_parity !== 1'b1) begin errors++; $display("FAIL parity_7 got %0b want 1", bus.dev_parity); end
    push_word(32'h0000_0003);
    bus.dev_ready = 1'b1;
    tick();
    bus.dev_ready = 1'b0;
    checks++; if (bus.dev_parity !== 1'b0 || bus.dev_data !== 32'h3) begin errors++; $display("FAIL parity_3 got par=%0b data=%h want 0/3", bus.dev_parity, bus.dev_data); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_push();
    test_held_strobe();
    test_full_overflow();
    test_push_pop_full();
    test_ovf_clr();
    test_async_clear();
`ifdef OUTPORT_DRAIN_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/outport_drain_buffer.md
Name: outport_drain_buffer

Overview:
- Device-side receiver for the datapath Outport.
- Each CPU write to the Outport register (the Outports load enable, plus the Outport data) is captured into a small FIFO.
- The FIFO is drained to an external consumer over a valid/ready handshake.
- It sits between the Bus datapath's OutportOut/Outports signals and off-core I/O, so the CPU never stalls on a slow device.

Parameters:
- DATA_W, 32, width of the Outport word.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- ADDR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- clr  input  1  asynchronous, active-high reset.
- out_data  input  DATA_W  Outport register contents (OutportOut).
- out_strobe  input  1  Outport load enable from the control unit; may be held high for several cycles.
- dev_data  output  DATA_W  FIFO head word presented to the device.
- dev_valid  output  1  dev_data holds a valid word.
- dev_ready  input  1  device accepts the word this cycle.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  ADDR_W+1  number of stored words, 0..DEPTH.
- overflow  output  1  sticky flag: a write was dropped.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (clr=1, asynchronous): all of the following take effect immediately, independent of clk, and hold while clr=1.
  - Pointers and count go to 0; the strobe history register goes to 0.
  - dev_valid=0, dev_data=0, empty=1, full=0, overflow=0.
- Write detect:
  - push = out_strobe & ~strobe_q, where strobe_q is out_strobe registered on clk.
  - Exactly one push per rising edge of out_strobe, regardless of how long the strobe is held.
  - out_data is sampled on the clk edge where push=1.
- Pop: pop = dev_valid & dev_ready.
- Write latency: a word pushed at edge N appears on dev_data with dev_valid=1 after edge N. There is no combinational bypass from out_data to dev_data.
- Output timing:
  - dev_data is registered and updates only on a pop or when the FIFO goes from empty to non-empty.
  - dev_data is stable while dev_valid=1 and dev_ready=0.
- Ordering: strict FIFO; the read pointer and write pointer wrap modulo DEPTH.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged; both pointers advance.
- Full:
  - A push with no simultaneous pop is dropped, and overflow is set on that edge.
  - A push with a simultaneous pop is accepted; count stays at DEPTH.
- Empty: dev_valid=0; dev_ready is ignored and count never underflows.
- Overflow clear: ovf_clr=1 clears overflow on the next edge. If a drop occurs on the same edge, set wins and overflow=1.
- Reset mid-operation: stored words are discarded and no partial handshake survives. After clr deasserts, a strobe that is already high counts as a new rising edge (strobe_q=0).
- The FIFO control is a two-state FSM:
  - EMPTY → HOLD on push.
  - HOLD → EMPTY on a pop that leaves count == 0 with no push.
  - HOLD → HOLD otherwise.
  - dev_valid = (state == HOLD).

Optional Feature:
- Macro: OUTPORT_DRAIN_PARITY_EN.
- When defined:
  - Adds output port dev_parity (1 bit), the even parity (XOR reduction) of dev_data, stored per entry at push time.
  - dev_parity is registered alongside dev_data and resets to 0.
- When undefined: the port and storage are absent; all other behaviour is identical.

Test Plan:
- Reset, then out_data=0x00000032 with out_strobe high for 1 cycle and dev_ready=0 → one cycle later dev_valid=1, dev_data=0x32, count=1; dev_data holds for 5 cycles.
- out_strobe held high for 4 cycles with out_data=0x12 → exactly one entry, count=1.
- Push 0x11, 0x22, 0x33, 0x44 with dev_ready=0 → full=1. A fifth push of 0x55 → dropped, overflow=1, count=4. Raise dev_ready → device sees 0x11, 0x22, 0x33, 0x44 in order, then empty=1.
- While full, push 0x66 in the same cycle dev_ready=1 → 0x11 popped, 0x66 accepted, count stays 4. Last word drained is 0x66.
- With overflow=1, assert ovf_clr in the same cycle as another dropped push → overflow stays 1. ovf_clr on the next cycle alone → overflow=0.
- Assert clr asynchronously mid-drain with count=3 → dev_valid, count, and overflow go to 0 before the next clk edge. With parity enabled, pushing 0x00000007 → dev_parity=1.
